// File: rtl/ex_pipe_ctrl_if.sv
// EX-stage sequencer bus: ID/EX and IF/ID hazard inputs, pipe control outputs.
interface ex_pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             VALID_DE;
   logic             MEMREAD_DE;
   logic             MC_OP_DE;
   logic [4:0]       RD_DE;
   logic [4:0]       RS1_FD;
   logic [4:0]       RS2_FD;
   logic             USE_RS1_FD;
   logic             USE_RS2_FD;
   logic             isBranch_E;
   logic [31:0]      PC_IMM_E;
   logic             STALL_F;
   logic             STALL_D;
   logic             HOLD_E;
   logic             BUBBLE_E;
   logic             FLUSH_D;
   logic             PC_SEL;
   logic [31:0]      PC_TGT;
   logic             MC_DONE;
   logic             BUSY;
   logic [CNT_W-1:0] STALL_CNT;
   logic [CNT_W-1:0] REDIR_CNT;

   modport slave (
      input  VALID_DE, MEMREAD_DE, MC_OP_DE, RD_DE, RS1_FD, RS2_FD,
             USE_RS1_FD, USE_RS2_FD, isBranch_E, PC_IMM_E,
      output STALL_F, STALL_D, HOLD_E, BUBBLE_E, FLUSH_D, PC_SEL, PC_TGT,
             MC_DONE, BUSY, STALL_CNT, REDIR_CNT
   );

   modport master (
      output VALID_DE, MEMREAD_DE, MC_OP_DE, RD_DE, RS1_FD, RS2_FD,
             USE_RS1_FD, USE_RS2_FD, isBranch_E, PC_IMM_E,
      input  STALL_F, STALL_D, HOLD_E, BUBBLE_E, FLUSH_D, PC_SEL, PC_TGT,
             MC_DONE, BUSY, STALL_CNT, REDIR_CNT
   );
endinterface

// File: rtl/ex_pipe_ctrl.sv
// EX-stage pipeline sequencer: branch redirect, load-use bubble, multi-cycle
// op hold, plus stall/redirect perf counters.
module ex_pipe_ctrl #(
   parameter int MC_LAT = 4,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RST_N,
   ex_pipe_ctrl_if.slave     bus
);
   localparam int CW = $clog2(MC_LAT) + 1;
   // first cycle of the op is spent in RUN, so the wait count starts at LAT-2
   localparam logic [CW-1:0] CNT_INIT = (MC_LAT > 1) ? CW'(MC_LAT - 2) : '0;

   typedef enum logic {RUN, MC_WAIT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

   logic        stall_f, stall_d, hold_e, bubble_e, flush_d, pc_sel, mc_done, busy;
   logic [31:0] pc_tgt;
   logic        load_use;

   assign load_use = bus.VALID_DE & bus.MEMREAD_DE & (bus.RD_DE != 5'd0) &
                     ((bus.USE_RS1_FD & (bus.RS1_FD == bus.RD_DE)) |
                      (bus.USE_RS2_FD & (bus.RS2_FD == bus.RD_DE)));

   // next-state and control outputs; everything is forced low while in reset
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      hold_e   = 1'b0;
      bubble_e = 1'b0;
      flush_d  = 1'b0;
      pc_sel   = 1'b0;
      pc_tgt   = '0;
      mc_done  = 1'b0;
      busy     = 1'b0;
      if (RST_N) begin
         case (state_q)
            RUN: begin
               if (bus.VALID_DE & bus.MC_OP_DE) begin
                  // a multi-cycle op owns EX; any branch flag is not acted on
                  if (MC_LAT > 1) begin
                     stall_f = 1'b1;
                     stall_d = 1'b1;
                     hold_e  = 1'b1;
                     state_d = MC_WAIT;
                     cnt_d   = CNT_INIT;
                  end else begin
                     mc_done = 1'b1;
                  end
               end else if (bus.VALID_DE & bus.isBranch_E) begin
                  // the flush kills the dependent instruction, so no load-use stall
                  pc_sel   = 1'b1;
                  pc_tgt   = bus.PC_IMM_E;
                  flush_d  = 1'b1;
                  bubble_e = 1'b1;
               end else if (load_use) begin
                  stall_f  = 1'b1;
                  stall_d  = 1'b1;
                  bubble_e = 1'b1;
               end
            end
            MC_WAIT: begin
               busy = 1'b1;
               if (cnt_q != '0) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  hold_e  = 1'b1;
                  cnt_d   = cnt_q - 1'b1;
               end else begin
                  mc_done = 1'b1;
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // perf counters wrap naturally
   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(stall_f);
      redir_cnt_d = redir_cnt_q + CNT_W'(pc_sel);
   end

   // state, wait counter and perf counter registers
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign bus.STALL_F   = stall_f;
   assign bus.STALL_D   = stall_d;
   assign bus.HOLD_E    = hold_e;
   assign bus.BUBBLE_E  = bubble_e;
   assign bus.FLUSH_D   = flush_d;
   assign bus.PC_SEL    = pc_sel;
   assign bus.PC_TGT    = pc_tgt;
   assign bus.MC_DONE   = mc_done;
   assign bus.BUSY      = busy;
   assign bus.STALL_CNT = stall_cnt_q;
   assign bus.REDIR_CNT = redir_cnt_q;
endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Directed bench for ex_pipe_ctrl: table of single-cycle RUN cases plus
// hand sequences for multi-cycle ops, reset abort, MC_LAT=1 and counter wrap.
module tb_ex_pipe_ctrl;
   logic CLK = 1'b0;
   logic RST_N;
   always #5 CLK = ~CLK;

   ex_pipe_ctrl_if #(.CNT_W(32)) if1 ();
   ex_pipe_ctrl_if #(.CNT_W(4))  if2 ();

   ex_pipe_ctrl #(.MC_LAT(4), .CNT_W(32)) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(if1));
   ex_pipe_ctrl #(.MC_LAT(1), .CNT_W(4))  dut2 (.CLK(CLK), .RST_N(RST_N), .bus(if2));

   typedef struct {
      logic        valid, memread, mc_op;
      logic [4:0]  rd, rs1, rs2;
      logic        use1, use2, br;
      logic [31:0] pc_imm;
      logic [7:0]  exp_ctrl;  // {STALL_F,STALL_D,HOLD_E,BUBBLE_E,FLUSH_D,PC_SEL,MC_DONE,BUSY}
      logic [31:0] exp_tgt;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vecs[10];
   int exp_stall = 0;
   int exp_redir = 0;

   localparam logic [7:0] C_NONE  = 8'b0000_0000;
   localparam logic [7:0] C_LU    = 8'b1101_0000;
   localparam logic [7:0] C_BR    = 8'b0001_1100;
   localparam logic [7:0] C_MCS   = 8'b1110_0000;
   localparam logic [7:0] C_MCW   = 8'b1110_0001;
   localparam logic [7:0] C_MCD   = 8'b0000_0011;
   localparam logic [7:0] C_DONE1 = 8'b0000_0010;

   function automatic vec_t mk(logic v, logic mr, logic mc, logic [4:0] rd, logic [4:0] r1,
                               logic [4:0] r2, logic u1, logic u2, logic br, logic [31:0] imm,
                               logic [7:0] ec, logic [31:0] et);
      vec_t t;
      t.valid = v; t.memread = mr; t.mc_op = mc; t.rd = rd; t.rs1 = r1; t.rs2 = r2;
      t.use1 = u1; t.use2 = u2; t.br = br; t.pc_imm = imm; t.exp_ctrl = ec; t.exp_tgt = et;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] ctrl1();
      return {if1.STALL_F, if1.STALL_D, if1.HOLD_E, if1.BUBBLE_E, if1.FLUSH_D,
              if1.PC_SEL, if1.MC_DONE, if1.BUSY};
   endfunction

   function automatic logic [7:0] ctrl2();
      return {if2.STALL_F, if2.STALL_D, if2.HOLD_E, if2.BUBBLE_E, if2.FLUSH_D,
              if2.PC_SEL, if2.MC_DONE, if2.BUSY};
   endfunction

   task automatic drive1(input vec_t t);
      if1.VALID_DE = t.valid; if1.MEMREAD_DE = t.memread; if1.MC_OP_DE = t.mc_op;
      if1.RD_DE = t.rd; if1.RS1_FD = t.rs1; if1.RS2_FD = t.rs2;
      if1.USE_RS1_FD = t.use1; if1.USE_RS2_FD = t.use2;
      if1.isBranch_E = t.br; if1.PC_IMM_E = t.pc_imm;
   endtask

   task automatic drive2(input vec_t t);
      if2.VALID_DE = t.valid; if2.MEMREAD_DE = t.memread; if2.MC_OP_DE = t.mc_op;
      if2.RD_DE = t.rd; if2.RS1_FD = t.rs1; if2.RS2_FD = t.rs2;
      if2.USE_RS1_FD = t.use1; if2.USE_RS2_FD = t.use2;
      if2.isBranch_E = t.br; if2.PC_IMM_E = t.pc_imm;
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      vec_t idle, mcv, luv;
      idle = mk(0,0,0, 0,0,0, 0,0,0, 32'h0, C_NONE, 32'h0);
      mcv  = mk(1,0,1, 3,0,0, 0,0,1, 32'h0000_0080, C_NONE, 32'h0);
      luv  = mk(1,1,0, 5,0,5, 0,1,0, 32'h0, C_LU, 32'h0);

      vecs[0] = idle;
      vecs[1] = luv;
      vecs[2] = mk(1,1,0, 0,0,0, 0,1,0, 32'h0, C_NONE, 32'h0);
      vecs[3] = mk(1,1,0, 7,7,1, 1,0,0, 32'h0, C_LU, 32'h0);
      vecs[4] = mk(1,1,0, 7,7,1, 0,0,0, 32'h0, C_NONE, 32'h0);
      vecs[5] = mk(1,0,0, 9,9,9, 1,1,0, 32'h0, C_NONE, 32'h0);
      vecs[6] = mk(0,1,0, 9,9,9, 1,1,0, 32'h0, C_NONE, 32'h0);
      vecs[7] = mk(1,0,0, 2,0,0, 0,0,1, 32'h0000_0040, C_BR, 32'h0000_0040);
      vecs[8] = mk(1,1,0, 5,0,5, 0,1,1, 32'h1234_5678, C_BR, 32'h1234_5678);
      vecs[9] = mk(0,0,0, 2,0,0, 0,0,1, 32'h0000_0040, C_NONE, 32'h0);

      // reset: outputs low even with a hazard presented
      RST_N = 1'b0;
      drive1(luv);
      drive2(luv);
      tick(); tick();
      chk("rst_ctrl", 64'(ctrl1()), 64'(C_NONE));
      chk("rst_ctrl2", 64'(ctrl2()), 64'(C_NONE));
      chk("rst_stall_cnt", 64'(if1.STALL_CNT), 64'd0);
      chk("rst_redir_cnt", 64'(if1.REDIR_CNT), 64'd0);
      drive1(idle);
      drive2(idle);
      RST_N = 1'b1;
      tick();

      // table: single-cycle RUN decisions
      for (int i = 0; i < 10; i++) begin
         drive1(vecs[i]);
         #2;
         chk($sformatf("vec%0d_ctrl", i), 64'(ctrl1()), 64'(vecs[i].exp_ctrl));
         chk($sformatf("vec%0d_tgt", i), 64'(if1.PC_TGT), 64'(vecs[i].exp_tgt));
         exp_stall += int'(vecs[i].exp_ctrl[7]);
         exp_redir += int'(vecs[i].exp_ctrl[2]);
         tick();
         chk($sformatf("vec%0d_stall_cnt", i), 64'(if1.STALL_CNT), 64'(exp_stall));
         chk($sformatf("vec%0d_redir_cnt", i), 64'(if1.REDIR_CNT), 64'(exp_redir));
      end
      drive1(idle);
      tick();

      // multi-cycle op, MC_LAT=4, branch flag set throughout and ignored
      drive1(mcv);
      #2;
      chk("mc_c1", 64'(ctrl1()), 64'(C_MCS));
      chk("mc_c1_tgt", 64'(if1.PC_TGT), 64'h0);
      tick();
      chk("mc_c2", 64'(ctrl1()), 64'(C_MCW));
      tick();
      chk("mc_c3", 64'(ctrl1()), 64'(C_MCW));
      tick();
      chk("mc_c4", 64'(ctrl1()), 64'(C_MCD));
      drive1(idle);
      tick();
      chk("mc_after", 64'(ctrl1()), 64'(C_NONE));
      chk("mc_stall_cnt", 64'(if1.STALL_CNT), 64'(exp_stall + 3));
      chk("mc_redir_cnt", 64'(if1.REDIR_CNT), 64'(exp_redir));

      // reset two cycles while in MC_WAIT: op aborted, no MC_DONE afterwards
      drive1(mcv);
      tick();
      chk("abort_busy", 64'(if1.BUSY), 64'd1);
      RST_N = 1'b0;
      #2;
      chk("abort_rst_ctrl_a", 64'(ctrl1()), 64'(C_NONE));
      tick();
      chk("abort_rst_ctrl_b", 64'(ctrl1()), 64'(C_NONE));
      tick();
      drive1(idle);
      RST_N = 1'b1;
      #2;
      chk("abort_ctrl", 64'(ctrl1()), 64'(C_NONE));
      chk("abort_stall_cnt", 64'(if1.STALL_CNT), 64'd0);
      chk("abort_redir_cnt", 64'(if1.REDIR_CNT), 64'd0);
      tick();
      chk("abort_ctrl_next", 64'(ctrl1()), 64'(C_NONE));

      // MC_LAT=1: done in the same cycle, never stalls or goes busy
      drive2(mcv);
      #2;
      chk("lat1_ctrl", 64'(ctrl2()), 64'(C_DONE1));
      tick();
      drive2(idle);
      #2;
      chk("lat1_after", 64'(ctrl2()), 64'(C_NONE));
      chk("lat1_stall_cnt", 64'(if2.STALL_CNT), 64'd0);

      // CNT_W=4 wrap after 16 load-use stalls
      drive2(luv);
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 1)  chk("wrap_cnt1", 64'(if2.STALL_CNT), 64'd1);
         if (i == 15) chk("wrap_cnt15", 64'(if2.STALL_CNT), 64'd15);
         if (i == 16) chk("wrap_cnt16", 64'(if2.STALL_CNT), 64'd0);
      end
      drive2(idle);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
